mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: Q103H memory-access stage.
// Builds a word-aligned data-memory request with byte enables from the ALU address,
// store data and memory controls, holds it stable across wait states while stalling
// the pipeline, and aligns/extends returned load data into the Q104H register.
// Optional feature macro: MEM_MISALIGN_CHK_EN (misaligned H/W accesses are suppressed
// and flagged on misalign_Q103H; when undefined, misalign_Q103H is tied 0 and
// surplus low address bits are ignored).

typedef struct packed {
    logic ready_Q103H;
    logic dmem_wr_en_Q103H;
    logic dmem_rd_en_Q103H;
} t_ma_ctrl;

typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_en;
} t_core2mem_req;

module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_Q103H,
    input  t_ma_ctrl      ma_ctrl,
    input  logic [2:0]    funct3_Q103H,
    input  logic [31:0]   alu_out_Q103H,
    input  logic [31:0]   rs2_data_Q103H,
    output t_core2mem_req core2mem_req,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rd_data,
    output logic          stall_Q103H,
    output logic [31:0]   dmem_rd_data_Q104H,
    output logic          misalign_Q103H
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } t_state;

    // Everything needed to keep driving the request and to extract the load
    // result once the memory finally acks.
    typedef struct packed {
        t_core2mem_req req;
        logic [2:0]    funct3;
        logic [1:0]    off;
    } t_hold;

    // funct3[1:0] encodes the access size: 00 byte, 01 halfword, otherwise word.
    function automatic logic [3:0] calc_byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] calc_wr_data(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{rs2[7:0]}};
            2'b01:   wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

    // Select the addressed byte/halfword lane and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'd0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    t_state        r_state;
    t_state        w_state_nxt;
    t_hold         r_hold;
    logic [1:0]    w_off;
    logic [ADDR_W-1:0] w_addr_aligned;
    logic          w_access;
    logic          w_misalign;
    logic          w_issue;
    t_core2mem_req w_live_req;
    logic [2:0]    w_sel_f3;
    logic [1:0]    w_sel_off;
    logic          w_load_done;

    assign w_off          = alu_out_Q103H[1:0];
    assign w_addr_aligned = {alu_out_Q103H[ADDR_W-1:2], 2'b00};
    assign w_access       = valid_Q103H & ma_ctrl.ready_Q103H &
                            (ma_ctrl.dmem_wr_en_Q103H | ma_ctrl.dmem_rd_en_Q103H);

`ifdef MEM_MISALIGN_CHK_EN
    // Halfword on an odd byte or word off a word boundary is refused outright.
    assign w_misalign = w_access &
                        (((funct3_Q103H[1:0] == 2'b01) & w_off[0]) |
                         ((funct3_Q103H[1:0] == 2'b10) & (w_off != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_access & ~w_misalign;

    // Request as seen live from Q103H; enables only assert on a real issue.
    always_comb begin
        w_live_req.address = w_addr_aligned;
        w_live_req.byte_en = calc_byte_en(funct3_Q103H, w_off);
        w_live_req.wr_data = calc_wr_data(funct3_Q103H, rs2_data_Q103H);
        w_live_req.wr_en   = w_issue & ma_ctrl.dmem_wr_en_Q103H;
        w_live_req.rd_en   = w_issue & ma_ctrl.dmem_rd_en_Q103H;
    end

    // Next state, request mux, stall and load-completion decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        w_state_nxt    = r_state;
        core2mem_req   = w_live_req;
        w_sel_f3       = funct3_Q103H;
        w_sel_off      = w_off;
        w_load_done    = 1'b0;
        stall_Q103H    = 1'b0;
        misalign_Q103H = 1'b0;
        case (r_state)
            ST_IDLE: begin
                misalign_Q103H = w_misalign;
                if (w_issue) begin
                    if (mem_ack) begin
                        w_load_done = w_live_req.rd_en;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        stall_Q103H = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                core2mem_req = r_hold.req;
                w_sel_f3     = r_hold.funct3;
                w_sel_off    = r_hold.off;
                if (mem_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_load_done = r_hold.req.rd_en;
                end else begin
                    stall_Q103H = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Reset abandons any request in flight: nothing may reach memory this cycle.
        if (rst) begin
            w_state_nxt        = ST_IDLE;
            core2mem_req.wr_en = 1'b0;
            core2mem_req.rd_en = 1'b0;
            stall_Q103H        = 1'b0;
            misalign_Q103H     = 1'b0;
            w_load_done        = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding register captures the request when memory does not ack on issue.
    always_ff @(posedge clk) begin
        // NOTE: the holding register is reset explicitly so that no stale enable
        // can be replayed after reset; it is a handful of flops, not a RAM.
        if (rst) begin
            r_hold <= '0;
        end else if ((r_state == ST_IDLE) && w_issue && !mem_ack) begin
            r_hold.req    <= w_live_req;
            r_hold.funct3 <= funct3_Q103H;
            r_hold.off    <= w_off;
        end
    end

    // Q104H load result: updates only when a load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_rd_data_Q104H <= '0;
        end else if (w_load_done) begin
            dmem_rd_data_Q104H <= load_extract(w_sel_f3, w_sel_off, mem_rd_data);
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a table of zero-wait accesses with
// hand-computed request fields and Q104H results, plus directed sequences for
// reset, ready-low/spurious ack, wait states, misalignment and reset during WAIT.

module tb_mem_access_stage;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_Q103H;
    t_ma_ctrl      ma_ctrl;
    logic [2:0]    funct3_Q103H;
    logic [31:0]   alu_out_Q103H;
    logic [31:0]   rs2_data_Q103H;
    t_core2mem_req core2mem_req;
    logic          mem_ack;
    logic [31:0]   mem_rd_data;
    logic          stall_Q103H;
    logic [31:0]   dmem_rd_data_Q104H;
    logic          misalign_Q103H;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_Q103H        (valid_Q103H),
        .ma_ctrl            (ma_ctrl),
        .funct3_Q103H       (funct3_Q103H),
        .alu_out_Q103H      (alu_out_Q103H),
        .rs2_data_Q103H     (rs2_data_Q103H),
        .core2mem_req       (core2mem_req),
        .mem_ack            (mem_ack),
        .mem_rd_data        (mem_rd_data),
        .stall_Q103H        (stall_Q103H),
        .dmem_rd_data_Q104H (dmem_rd_data_Q104H),
        .misalign_Q103H     (misalign_Q103H)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] mem;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rdy, input logic wr, input logic rd,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2,
                         input logic ack, input logic [31:0] md);
        valid_Q103H              = v;
        ma_ctrl.ready_Q103H      = rdy;
        ma_ctrl.dmem_wr_en_Q103H = wr;
        ma_ctrl.dmem_rd_en_Q103H = rd;
        funct3_Q103H             = f3;
        alu_out_Q103H            = a;
        rs2_data_Q103H           = rs2;
        mem_ack                  = ack;
        mem_rd_data              = md;
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        int stall_cnt;

        //            wr    rd    f3      addr          rs2           mem           exp_addr      be       wd            q
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_2002, 32'h0,        32'h0080_0000, 32'h0000_2000, 4'b0100, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 1'b1, 3'b100, 32'h0000_2002, 32'h0,        32'h0080_0000, 32'h0000_2000, 4'b0100, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0,        32'h8001_1234, 32'h0000_3000, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[4]  = '{1'b0, 1'b1, 3'b101, 32'h0000_3002, 32'h0,        32'h8001_1234, 32'h0000_3000, 4'b1100, 32'h0,        32'h0000_8001};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 32'h0000_8001};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_4004, 4'b1111, 32'hDEAD_BEEF, 32'h0000_8001};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_4008, 32'h0,        32'h1234_5678, 32'h0000_4008, 4'b1111, 32'h0,        32'h1234_5678};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h0,        32'h0000_FF00, 32'h0000_1000, 4'b0010, 32'h0,        32'hFFFF_FFFF};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h0,        32'h0000_007F, 32'h0000_1000, 4'b0001, 32'h0,        32'h0000_007F};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h0000_1000, 32'h0,        32'h0000_7FFF, 32'h0000_1000, 4'b0011, 32'h0,        32'h0000_7FFF};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h0000_1002, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_1000, 4'b0100, 32'h7878_7878, 32'h0000_7FFF};

        // Reset: a valid load presented during reset must not reach memory.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 1'b0, 32'h0);
        check("rst_rd_en", 32'(core2mem_req.rd_en), 32'h0);
        check("rst_wr_en", 32'(core2mem_req.wr_en), 32'h0);
        check("rst_stall", 32'(stall_Q103H), 32'h0);
        check("rst_misalign", 32'(misalign_Q103H), 32'h0);
        step();
        step();
        check("rst_q104", dmem_rd_data_Q104H, 32'h0);
        rst = 1'b0;

        // Spurious ack with no instruction: ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 32'hFFFF_FFFF);
        check("spur_stall", 32'(stall_Q103H), 32'h0);
        step();
        check("spur_q104", dmem_rd_data_Q104H, 32'h0);

        // ready low in IDLE: no issue, no stall, ack ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 32'hFFFF_FFFF);
        check("nrdy_rd_en", 32'(core2mem_req.rd_en), 32'h0);
        check("nrdy_stall", 32'(stall_Q103H), 32'h0);
        step();
        check("nrdy_q104", dmem_rd_data_Q104H, 32'h0);

        // Zero-wait access table.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, vecs[i].wr, vecs[i].rd, vecs[i].f3, vecs[i].addr, vecs[i].rs2,
                  1'b1, vecs[i].mem);
            check($sformatf("v%0d_addr", i), core2mem_req.address, vecs[i].exp_addr);
            check($sformatf("v%0d_be", i), 32'(core2mem_req.byte_en), 32'(vecs[i].exp_be));
            check($sformatf("v%0d_wd", i), core2mem_req.wr_data, vecs[i].exp_wd);
            check($sformatf("v%0d_en", i), 32'({core2mem_req.wr_en, core2mem_req.rd_en}),
                  32'({vecs[i].wr, vecs[i].rd}));
            check($sformatf("v%0d_stall", i), 32'(stall_Q103H), 32'h0);
            step();
            drive_idle();
            check($sformatf("v%0d_q104", i), dmem_rd_data_Q104H, vecs[i].exp_q);
        end

        // Three wait states on LW 0x4000 while Q103H inputs churn.
        stall_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0)
                drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h7777_7771 + 32'(c), 32'h0000_FFFF,
                      (c == 3), 32'hCAFE_F00D);
            if (stall_Q103H) stall_cnt++;
            check($sformatf("wait%0d_addr", c), core2mem_req.address, 32'h0000_4000);
            check($sformatf("wait%0d_be", c), 32'(core2mem_req.byte_en), 32'hF);
            check($sformatf("wait%0d_en", c), 32'({core2mem_req.wr_en, core2mem_req.rd_en}), 32'h1);
            check($sformatf("wait%0d_stall", c), 32'(stall_Q103H), (c == 3) ? 32'h0 : 32'h1);
            step();
        end
        drive_idle();
        check("wait_stall_cycles", 32'(stall_cnt), 32'd3);
        check("wait_q104", dmem_rd_data_Q104H, 32'hCAFE_F00D);

        // Misaligned accesses.
`ifdef MEM_MISALIGN_CHK_EN
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_5001, 32'h0, 1'b1, 32'h55AA_55AA);
        check("mis_w_flag", 32'(misalign_Q103H), 32'h1);
        check("mis_w_rd_en", 32'(core2mem_req.rd_en), 32'h0);
        check("mis_w_stall", 32'(stall_Q103H), 32'h0);
        step();
        drive_idle();
        check("mis_w_flag_clr", 32'(misalign_Q103H), 32'h0);
        check("mis_w_q104", dmem_rd_data_Q104H, 32'hCAFE_F00D);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_1003, 32'h0, 1'b1, 32'hC000_0000);
        check("mis_h_flag", 32'(misalign_Q103H), 32'h1);
        check("mis_h_rd_en", 32'(core2mem_req.rd_en), 32'h0);
        step();
        drive_idle();
        check("mis_h_q104", dmem_rd_data_Q104H, 32'hCAFE_F00D);
`else
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_5001, 32'h0, 1'b1, 32'h55AA_55AA);
        check("mis_w_flag", 32'(misalign_Q103H), 32'h0);
        check("mis_w_rd_en", 32'(core2mem_req.rd_en), 32'h1);
        check("mis_w_addr", core2mem_req.address, 32'h0000_5000);
        check("mis_w_be", 32'(core2mem_req.byte_en), 32'hF);
        step();
        drive_idle();
        check("mis_w_q104", dmem_rd_data_Q104H, 32'h55AA_55AA);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_1003, 32'h0, 1'b1, 32'hC000_0000);
        check("mis_h_flag", 32'(misalign_Q103H), 32'h0);
        check("mis_h_be", 32'(core2mem_req.byte_en), 32'hC);
        step();
        drive_idle();
        check("mis_h_q104", dmem_rd_data_Q104H, 32'hFFFF_C000);
`endif

        // Reset while in WAIT, followed by a late ack.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'h0, 1'b0, 32'h0);
        check("rw_issue_stall", 32'(stall_Q103H), 32'h1);
        step();
        drive_idle();
        check("rw_wait_stall", 32'(stall_Q103H), 32'h1);
        check("rw_wait_rd_en", 32'(core2mem_req.rd_en), 32'h1);
        rst = 1'b1;
        #1;
        check("rw_rst_stall", 32'(stall_Q103H), 32'h0);
        check("rw_rst_rd_en", 32'(core2mem_req.rd_en), 32'h0);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        check("rw_late_stall", 32'(stall_Q103H), 32'h0);
        check("rw_late_en", 32'({core2mem_req.wr_en, core2mem_req.rd_en}), 32'h0);
        check("rw_rst_q104", dmem_rd_data_Q104H, 32'h0);
        step();
        drive_idle();
        check("rw_late_q104", dmem_rd_data_Q104H, 32'h0);
        check("rw_idle_stall", 32'(stall_Q103H), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
